// File: rtl/outfifo_reader_pkg.sv
// Shared types and constants for the nibble-FIFO reader.
package outfifo_reader_pkg;

   localparam int NIBBLE_W      = 4;
   localparam int BYTE_W        = 8;
   localparam int OUT_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAP_LO  = 2'd1,
      WAIT_HI = 2'd2,
      CAP_HI  = 2'd3
   } state_t;

endpackage

// File: rtl/byte_skid_fifo.sv
// Circular byte buffer between nibble assembly and the downstream handshake.
module byte_skid_fifo
   import outfifo_reader_pkg::*;
#(
   parameter int DEPTH = OUT_DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic [BYTE_W-1:0]         push_data,
   input  logic                      pop,
   output logic [BYTE_W-1:0]         head,
   output logic [$clog2(DEPTH):0]    occ
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_pop;

   assign do_pop = pop & (count != '0);
   assign head   = mem[rd_ptr];
   assign occ    = count;

   // Entries are cleared too so the head byte reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/outfifo_reader.sv
// Drains the 4-bit output FIFO and packs nibble pairs into bytes with valid/ready.
// OUTFIFO_HI_FIRST_EN: first nibble read lands in bits [7:4] instead of [3:0].
module outfifo_reader #(
   parameter int OUT_DEPTH = outfifo_reader_pkg::OUT_DEPTH_DEF,
   parameter int NIBBLE_W  = outfifo_reader_pkg::NIBBLE_W
) (
   input  logic                                 inClock,
   input  logic                                 inReset,
   input  logic [NIBBLE_W-1:0]                  in_fifo_inData,
   input  logic                                 in_fifo_inEmpty,
   output logic                                 out_fifo_outReadEnable,
   output logic [outfifo_reader_pkg::BYTE_W-1:0] out_outByte,
   output logic                                 out_outValid,
   input  logic                                 in_inReady,
   output logic [$clog2(OUT_DEPTH):0]           out_outOcc
);

   // state   | meaning
   // IDLE    | no byte under assembly
   // CAP_LO  | first nibble arrives this cycle
   // WAIT_HI | first nibble held, FIFO empty
   // CAP_HI  | second nibble arrives, byte pushed

   import outfifo_reader_pkg::*;

   localparam int              OCC_W   = $clog2(OUT_DEPTH) + 1;
   localparam logic [OCC_W:0]  DEPTH_X = (OCC_W+1)'(OUT_DEPTH);

   state_t               state;
   state_t               state_nxt;
   logic [NIBBLE_W-1:0]  first_q;
   logic                 read_en;
   logic                 push;
   logic                 pop;
   logic                 assembling;
   logic                 credit;
   logic                 room_next;
   logic [OCC_W-1:0]     occ;
   logic [OCC_W:0]       occ_x;
   logic [OCC_W:0]       need_first;
   logic [OCC_W:0]       need_next;
   logic [BYTE_W-1:0]    push_byte;

   assign pop          = out_outValid & in_inReady;
   assign out_outValid = (occ != '0);
   assign out_outOcc   = occ;
   assign assembling   = (state != IDLE);

   // A first-nibble read reserves a buffer slot for the byte it starts.
   assign occ_x      = {1'b0, occ};
   assign need_first = occ_x + (OCC_W+1)'(assembling) - (OCC_W+1)'(pop);
   assign need_next  = occ_x + (OCC_W+1)'(2) - (OCC_W+1)'(pop);
   assign credit     = need_first < DEPTH_X;
   assign room_next  = need_next <= DEPTH_X;

`ifdef OUTFIFO_HI_FIRST_EN
   assign push_byte = {first_q, in_fifo_inData};
`else
   assign push_byte = {in_fifo_inData, first_q};
`endif

   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         state   <= IDLE;
         first_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == CAP_LO) first_q <= in_fifo_inData;
      end
   end

   always_comb begin
      state_nxt = state;
      read_en   = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (!in_fifo_inEmpty && credit) begin
               read_en   = 1'b1;
               state_nxt = CAP_LO;
            end
         end
         CAP_LO: begin
            if (!in_fifo_inEmpty) begin
               read_en   = 1'b1;
               state_nxt = CAP_HI;
            end else begin
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (!in_fifo_inEmpty) begin
               read_en   = 1'b1;
               state_nxt = CAP_HI;
            end
         end
         CAP_HI: begin
            push = 1'b1;
            if (!in_fifo_inEmpty && room_next) begin
               read_en   = 1'b1;
               state_nxt = CAP_LO;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Hold the pop strobe low for the whole reset window, not just after the first edge.
   assign out_fifo_outReadEnable = read_en & inReset;

   byte_skid_fifo #(
      .DEPTH (OUT_DEPTH)
   ) u_buf (
      .clk       (inClock),
      .rst_n     (inReset),
      .push      (push),
      .push_data (push_byte),
      .pop       (pop),
      .head      (out_outByte),
      .occ       (occ)
   );

endmodule

// File: tb/tb_outfifo_reader.sv
// Directed + random bench for outfifo_reader with a nibble-FIFO model and byte scoreboard.
module tb_outfifo_reader;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] fifo_data = 4'h0;
   logic       fifo_empty = 1'b1;
   logic       re;
   logic [7:0] ob;
   logic       ov;
   logic       rdy = 1'b0;
   logic [2:0] occ;

   always #5 clk = ~clk;

   outfifo_reader #(.OUT_DEPTH(DEPTH), .NIBBLE_W(4)) dut (
      .inClock                (clk),
      .inReset                (rst_n),
      .in_fifo_inData         (fifo_data),
      .in_fifo_inEmpty        (fifo_empty),
      .out_fifo_outReadEnable (re),
      .out_outByte            (ob),
      .out_outValid           (ov),
      .in_inReady             (rdy),
      .out_outOcc             (occ)
   );

   int         n_asserts = 0;
   int         n_fail = 0;
   int         n_bytes = 0;
   logic [3:0] fifo[$];
   logic [3:0] wr_q[$];
   logic [7:0] sb[$];
   bit         flush = 1'b0;
   logic       re_s = 1'b0;
   logic       vld_s = 1'b0;
   logic       half_v = 1'b0;
   logic [3:0] half = 4'h0;
   int         reads, first_re, first_v, nb0, run, max_run;
   bit         seen;

   function automatic logic [7:0] pair(input logic [3:0] first, input logic [3:0] second);
`ifdef OUTFIFO_HI_FIRST_EN
      return {first, second};
`else
      return {second, first};
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      check("re_while_empty", {31'd0, re & fifo_empty}, 0);
      check("occ_le_depth", {31'd0, occ <= 3'(DEPTH)}, 1);
      if (ov && rdy) begin
         n_bytes++;
         check("byte_expected", {31'd0, sb.size() != 0}, 1);
         if (sb.size() != 0) check("byte_value", {24'd0, ob}, {24'd0, sb.pop_front()});
      end
   endtask

   // One clock: sample at negedge, then advance the FIFO model at posedge.
   task automatic tick();
      @(negedge clk);
      if (rst_n) monitor();
      re_s  = re;
      vld_s = ov;
      @(posedge clk);
      if (re_s && fifo.size() != 0) fifo_data <= fifo.pop_front();
      while (wr_q.size() != 0) fifo.push_back(wr_q.pop_front());
      if (flush) begin
         fifo.delete();
         flush = 1'b0;
      end
      fifo_empty <= (fifo.size() == 0);
      #1;
   endtask

   task automatic write_raw(input logic [3:0] n);
      wr_q.push_back(n);
   endtask

   task automatic write_nib(input logic [3:0] n);
      if (!half_v) begin
         half   = n;
         half_v = 1'b1;
      end else begin
         sb.push_back(pair(half, n));
         half_v = 1'b0;
      end
      wr_q.push_back(n);
   endtask

   initial begin
      // reset values
      repeat (2) tick();
      check("rst_re", {31'd0, re}, 0);
      check("rst_valid", {31'd0, ov}, 0);
      check("rst_byte", {24'd0, ob}, 0);
      check("rst_occ", {29'd0, occ}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_no_read", {31'd0, re_s}, 0);
      end

      // streaming 3,A,5,C
      rdy = 1'b1;
`ifdef OUTFIFO_HI_FIRST_EN
      sb.push_back(8'h3A);
      sb.push_back(8'h5C);
`else
      sb.push_back(8'hA3);
      sb.push_back(8'hC5);
`endif
      write_raw(4'h3); write_raw(4'hA); write_raw(4'h5); write_raw(4'hC);
      reads = 0; run = 0; max_run = 0; first_re = -1; first_v = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (re_s) begin
            reads++;
            run++;
            if (first_re < 0) first_re = i;
         end else run = 0;
         if (run > max_run) max_run = run;
         if (vld_s && first_v < 0) first_v = i;
      end
      check("stream_reads", reads, 4);
      check("stream_run", max_run, 4);
      check("stream_latency", first_v - first_re, 3);
      check("stream_drained", sb.size(), 0);

      // starved second nibble
      sb.push_back(pair(4'h7, 4'h1));
      nb0 = n_bytes;
      write_raw(4'h7);
      reads = 0;
      repeat (7) begin
         tick();
         if (re_s) reads++;
      end
      check("starve_one_read", reads, 1);
      check("starve_no_valid", {31'd0, ov}, 0);
      check("starve_occ", {29'd0, occ}, 0);
      write_raw(4'h1);
      reads = 0; first_re = -1; first_v = -1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (re_s) begin
            reads++;
            if (first_re < 0) first_re = i;
         end
         if (vld_s && first_v < 0) first_v = i;
      end
      check("starve_second_read", reads, 1);
      check("starve_latency", first_v - first_re, 2);
      check("starve_bytes", n_bytes - nb0, 1);

      // backpressure with 12 nibbles
      rdy = 1'b0;
      for (int i = 0; i < 12; i++) write_nib(4'(i * 5 + 2));
      reads = 0;
      repeat (30) begin
         tick();
         if (re_s) reads++;
      end
      check("bp_reads", reads, 8);
      check("bp_occ", {29'd0, occ}, 4);
      check("bp_re_stalled", {31'd0, re}, 0);
      check("bp_valid", {31'd0, ov}, 1);
      rdy = 1'b1;
      reads = 0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         tick();
         if (re_s) reads++;
      end
      check("bp_resume_reads", reads, 4);
      check("bp_drained", sb.size(), 0);
      repeat (4) tick();
      check("bp_occ_empty", {29'd0, occ}, 0);

      // asynchronous reset mid-traffic
      rdy = 1'b0;
      for (int i = 0; i < 6; i++) write_raw(4'(i + 9));
      repeat (6) tick();
      check("pre_rst_valid", {31'd0, ov}, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_re", {31'd0, re}, 0);
      check("async_rst_valid", {31'd0, ov}, 0);
      check("async_rst_byte", {24'd0, ob}, 0);
      check("async_rst_occ", {29'd0, occ}, 0);
      flush = 1'b1;
      sb.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_no_read", {31'd0, re_s}, 0);
         check("post_rst_no_valid", {31'd0, vld_s}, 0);
      end

      // reset while a first nibble is held
      rdy = 1'b1;
      nb0 = n_bytes;
      write_raw(4'h9);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (re_s) seen = 1'b1;
      end
      check("mid_first_read", {31'd0, seen}, 1);
      tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      sb.push_back(pair(4'h2, 4'h4));
      write_raw(4'h2);
      write_raw(4'h4);
      repeat (10) tick();
      check("mid_bytes", n_bytes - nb0, 1);
      check("mid_drained", sb.size(), 0);

      // random empty/ready traffic
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 99) < 45) write_nib(4'($urandom_range(0, 15)));
         rdy = ($urandom_range(0, 99) < 60);
         tick();
      end
      if (half_v) write_nib(4'($urandom_range(0, 15)));
      rdy = 1'b1;
      for (int i = 0; i < 400 && (sb.size() != 0 || fifo.size() != 0 || wr_q.size() != 0); i++) tick();
      check("rnd_drained", sb.size(), 0);
      check("rnd_fifo_empty", fifo.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/outfifo_reader.md
# outfifo_reader

Drains the chip's 4-bit output FIFO through its read-enable/empty interface and reassembles nibble pairs into bytes behind a valid/ready handshake. It is the reading end of the nibble FIFO path; the nibble writer feeds the input FIFO on the other end. It sits beside the pad ring on the host/test side. It issues reads only when it has buffer space for the resulting byte, so it never drops data.

## Interface

Parameters:
- OUT_DEPTH, 4, number of byte entries in the output buffer (≥2, power of two).
- NIBBLE_W, 4, FIFO data width. Fixed at 4; any other value is illegal.

Ports:
- inClock, input, 1, sole clock, rising edge.
- inReset, input, 1, asynchronous active-low reset.
- in_fifo_inData, input, 4, FIFO read data. Valid in the cycle after a read-enable cycle.
- in_fifo_inEmpty, input, 1, FIFO empty flag. Registered by the FIFO and updated the cycle after a read.
- out_fifo_outReadEnable, output, 1, one pop of the FIFO per high cycle.
- out_outByte, output, 8, head byte of the output buffer.
- out_outValid, output, 1, out_outByte is valid.
- in_inReady, input, 1, downstream accepts the byte when out_outValid is also high.
- out_outOcc, output, log2(OUT_DEPTH)+1, output buffer occupancy.

## Operation

- FSM states:
  - IDLE: no byte under assembly.
  - CAP_LO: capture the first nibble this cycle.
  - WAIT_HI: first nibble held, FIFO empty.
  - CAP_HI: capture the second nibble and push the byte.
- Define the following signals:
  - pop = out_outValid & in_inReady.
  - asm = (state != IDLE).
  - credit = (occ + asm − pop < OUT_DEPTH).
- IDLE:
  - If !inEmpty and credit: ReadEnable=1 and go to CAP_LO.
  - Otherwise stay in IDLE.
- CAP_LO:
  - Latch inData as the first nibble.
  - If !inEmpty: ReadEnable=1 and go to CAP_HI.
  - Otherwise go to WAIT_HI.
- WAIT_HI:
  - If !inEmpty: ReadEnable=1 and go to CAP_HI.
  - The second-nibble read needs no credit, because it was reserved by the first read.
- CAP_HI:
  - Latch inData as the second nibble and push {hi,lo} into the buffer at the clock edge.
  - If !inEmpty and (occ + 2 − pop ≤ OUT_DEPTH): ReadEnable=1 and go to CAP_LO.
  - Otherwise go to IDLE.
- ReadEnable is never high while in_fifo_inEmpty=1. This is an assertion in the bench.
- Output buffer is a circular FIFO:
  - out_outValid = (occ != 0).
  - out_outByte = head entry.
  - Push and pop in the same cycle leave occ unchanged.
- Overflow is impossible by construction. A push into a full buffer is an assertion failure.
- Byte assembly, default order: the first nibble is bits [3:0] and the second nibble is bits [7:4].

## Timing

- Reset values:
  - ReadEnable=0, outValid=0, outByte=8'h00, outOcc=0.
  - State=IDLE, buffer pointers=0, nibble latch=0.
- Reset mid-operation discards any held nibble and all buffered bytes. The block restarts in IDLE.
- Latency from the first-nibble read (cycle 0) with the FIFO non-empty:
  - Second read in cycle 1.
  - Byte pushed at the end of cycle 2.
  - out_outValid high in cycle 3.
- Throughput: one nibble per cycle sustained, i.e. one byte per 2 cycles, when in_inReady=1 and OUT_DEPTH ≥ 2.
- Backpressure: with in_inReady=0, exactly OUT_DEPTH bytes are fetched. After that ReadEnable stays 0.
- Pointer wrap-around is modulo OUT_DEPTH, with no bubble.

## Configuration

- OUTFIFO_HI_FIRST_EN defined: the first nibble read is bits [7:4] and the second is bits [3:0].
- OUTFIFO_HI_FIRST_EN undefined: the first nibble read is bits [3:0] (low-first).
- Nothing else changes.

## Structure

- Package outfifo_reader_pkg holds:
  - The state enum (IDLE, CAP_LO, WAIT_HI, CAP_HI).
  - NIBBLE_W=4 and BYTE_W=8.
  - The default OUT_DEPTH.
- Sub-module byte_skid_fifo implements the output buffer:
  - Parameter DEPTH.
  - Ports: push, push_data, pop, head, occ.
- The top level contains the FSM, the credit logic and the nibble latch.

## Test plan

- Reset: assert inReset=0 mid-traffic → all outputs 0 immediately (asynchronously). After release, the FSM is in IDLE and ReadEnable stays 0 while inEmpty=1.
- Streaming: FIFO preloaded with 3, A, 5, C and in_inReady=1 →
  - ReadEnable high for 4 consecutive cycles.
  - Bytes 8'hA3 then 8'hC5.
  - With OUTFIFO_HI_FIRST_EN: 8'h3A then 8'h5C.
- Starved second nibble: FIFO holds only 7, then stays empty for 5 cycles, then 1 is written →
  - FSM sits in WAIT_HI.
  - A single byte 8'h17 is produced 2 cycles after the second read.
- Backpressure: 12 nibbles available and in_inReady=0 →
  - Exactly 8 read cycles, then outOcc=4 and ReadEnable=0.
  - On raising in_inReady, reads resume and the remaining 2 bytes arrive in order.
- Reset mid-assembly: reset asserted in the cycle after CAP_LO →
  - No byte is emitted from the held nibble.
  - The next byte is built only from nibbles read after reset.
- Random inEmpty/inReady toggling for 10k cycles →
  - No read while empty and no buffer overflow.
  - The byte sequence matches the scoreboard of FIFO contents.
